// File: rtl/cosine_stream_adapter_if.sv
// Valid/ready angle stream into the adapter and result stream out of it.
// The adapter takes the slave view; the producer/consumer side takes the master view.
interface cosine_stream_adapter_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_angle;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;

   modport slave (
      input  in_valid,
      input  in_angle,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_result
   );

   modport master (
      output in_valid,
      output in_angle,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_result
   );
endinterface

// File: rtl/cosine_stream_adapter.sv
// Streaming wrapper around a non-stallable pipelined cosine core: tags in-flight work,
// buffers results in a FIFO and only admits an angle when a FIFO slot is guaranteed.
module cosine_stream_adapter #(
   parameter int CORE_LATENCY = 4,
   parameter int FIFO_DEPTH   = 8,
   localparam int INFLIGHT_W  = $clog2(CORE_LATENCY + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   cosine_stream_adapter_if.slave s,
   output logic [31:0]           core_angle,
   output logic                  core_clk_en,
   output logic                  core_reset,
   input  logic [31:0]           core_result,
   output logic [INFLIGHT_W-1:0] inflight,
   output logic                  idle
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int SUM_W = ((CNT_W > INFLIGHT_W) ? CNT_W : INFLIGHT_W) + 1;

   logic [CORE_LATENCY-1:0] vld_q, vld_d;
   logic [INFLIGHT_W-1:0]   inflight_q, inflight_d;
   logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]        count_q, count_d;
   logic [31:0]             mem_q [FIFO_DEPTH];

   logic             fire;
   logic             push;
   logic             pop;
   logic             in_ready_int;
   logic             out_valid_int;
   logic [SUM_W-1:0] credit_used;

   // The core runs freely; its output is trusted only when the matching tag reaches the end.
   assign core_angle  = s.in_angle;
   assign core_clk_en = reset;
   assign core_reset  = ~reset;

   // Every accepted angle reserves a FIFO slot until it is popped, so a push can never overflow.
   assign credit_used  = SUM_W'(count_q) + SUM_W'(inflight_q);
   assign in_ready_int = reset & (credit_used < SUM_W'(FIFO_DEPTH));
   assign fire         = s.in_valid & in_ready_int;
   assign push         = vld_q[CORE_LATENCY-1];
   assign out_valid_int = (count_q != '0);
   assign pop          = out_valid_int & s.out_ready;

   assign s.in_ready   = in_ready_int;
   assign s.out_valid  = out_valid_int;
   assign s.out_result = out_valid_int ? mem_q[rd_ptr_q] : 32'h0;
   assign inflight     = inflight_q;
   assign idle         = (inflight_q == '0) && (count_q == '0);

   always_comb begin
      vld_d      = '0;
      inflight_d = inflight_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;

      vld_d[0] = fire;
      for (int k = 1; k < CORE_LATENCY; k++) begin
         vld_d[k] = vld_q[k-1];
      end

      if (fire && !push) begin
         inflight_d = inflight_q + INFLIGHT_W'(1);
      end else if (!fire && push) begin
         inflight_d = inflight_q - INFLIGHT_W'(1);
      end

      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      if (push && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (!push && pop) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_q      <= '0;
         inflight_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         vld_q      <= vld_d;
         inflight_q <= inflight_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   // Result storage is deliberately left out of reset; count_q alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= core_result;
      end
   end

endmodule

// File: tb/tb_cosine_stream_adapter.sv
// Randomised scoreboard bench for cosine_stream_adapter using a latency-4 core stub
// that returns angle+1, so every expected result is known exactly.
module tb_cosine_stream_adapter;

   localparam int CORE_LATENCY = 4;
   localparam int FIFO_DEPTH   = 8;
   localparam int IW           = $clog2(CORE_LATENCY + 1);

   logic          clk;
   logic          reset;
   logic [31:0]   core_angle;
   logic          core_clk_en;
   logic          core_reset;
   logic [31:0]   core_result;
   logic [IW-1:0] inflight;
   logic          idle;

   cosine_stream_adapter_if bus ();

   cosine_stream_adapter #(
      .CORE_LATENCY(CORE_LATENCY),
      .FIFO_DEPTH  (FIFO_DEPTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .s          (bus),
      .core_angle (core_angle),
      .core_clk_en(core_clk_en),
      .core_reset (core_reset),
      .core_result(core_result),
      .inflight   (inflight),
      .idle       (idle)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [31:0] expQ[$];
   int          arrQ[$];

   logic [31:0] stg [CORE_LATENCY];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Core stand-in: input register plus three stages, zeroed on reset or clock-enable low.
   always @(posedge clk) begin
      if (core_reset || !core_clk_en) begin
         for (int k = 0; k < CORE_LATENCY; k++) stg[k] <= 32'h0;
      end else begin
         stg[0] <= core_angle;
         for (int k = 1; k < CORE_LATENCY; k++) stg[k] <= stg[k-1];
      end
   end
   assign core_result = stg[CORE_LATENCY-1] + 32'h1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s at cycle %0d: got %h, wanted %h", name, cyc, actual, expected);
      end
   endtask

   logic lastFire;

   task automatic applyStimulus(input logic v, input logic [31:0] a, input logic ordy, input logic rst);
      @(posedge clk);
      #1;
      reset         = rst;
      bus.in_valid  = v;
      bus.in_angle  = a;
      bus.out_ready = ordy;
      #1;
      lastFire = v && bus.in_ready;
      if (lastFire) expQ.push_back(a + 32'h1);
   endtask

   // Monitor: in_ready/idle/inflight follow from the count of accepted-but-unpopped items,
   // out_valid from whether the oldest such item is at least five cycles old.
   always @(negedge clk) begin
      if (!reset) begin
         checkOutput("rst_in_ready", {31'h0, bus.in_ready}, 32'h0);
         checkOutput("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
         checkOutput("rst_out_result", bus.out_result, 32'h0);
         checkOutput("rst_idle", {31'h0, idle}, 32'h1);
         checkOutput("rst_inflight", 32'(inflight), 32'h0);
         checkOutput("rst_core_reset", {31'h0, core_reset}, 32'h1);
         expQ.delete();
         arrQ.delete();
      end else begin
         int  expInflight;
         logic expValid;
         expInflight = 0;
         foreach (arrQ[i]) if (arrQ[i] > cyc) expInflight++;
         expValid = (arrQ.size() > 0) && (arrQ[0] <= cyc);
         checkOutput("in_ready", {31'h0, bus.in_ready}, {31'h0, arrQ.size() < FIFO_DEPTH});
         checkOutput("out_valid", {31'h0, bus.out_valid}, {31'h0, expValid});
         checkOutput("inflight", 32'(inflight), 32'(expInflight));
         checkOutput("idle", {31'h0, idle}, {31'h0, arrQ.size() == 0});
         checkOutput("core_reset", {31'h0, core_reset}, 32'h0);
         checkOutput("core_clk_en", {31'h0, core_clk_en}, 32'h1);
         if (!bus.out_valid) checkOutput("out_result_idle", bus.out_result, 32'h0);
         if (bus.out_valid && bus.out_ready) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_result", bus.out_result, 32'hxxxxxxxx);
            end else begin
               checkOutput("out_result", bus.out_result, expQ[0]);
               void'(expQ.pop_front());
            end
            if (arrQ.size() > 0) void'(arrQ.pop_front());
         end
         if (bus.in_valid && bus.in_ready) arrQ.push_back(cyc + CORE_LATENCY + 1);
      end
   end

   // A push is only legal into a full FIFO when the same cycle also pops.
   always @(negedge clk) begin
      if (reset && dut.push) begin
         total++;
         assert (!((32'(dut.count_q) == FIFO_DEPTH) && !dut.pop))
         else begin
            bad++;
            $display("[TB] FAIL push_full at cycle %0d: count=%0d, wanted below %0d", cyc, dut.count_q, FIFO_DEPTH);
         end
      end
   end

   initial begin
      int fires;
      int t0;
      reset         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_angle  = 32'h0;
      bus.out_ready = 1'b0;
      lastFire      = 1'b0;

      $display("[TB] reset held with in_valid high");
      repeat (3) applyStimulus(1'b1, 32'h1234_5678, 1'b1, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

      $display("[TB] single operation");
      applyStimulus(1'b1, 32'h3F80_0000, 1'b1, 1'b1);
      repeat (8) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

      $display("[TB] back-to-back streaming");
      for (int i = 0; i < 16; i++) applyStimulus(1'b1, 32'h3F00_0000 + 32'(i), 1'b1, 1'b1);
      repeat (8) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

      $display("[TB] backpressure then drain");
      repeat (20) applyStimulus(1'b1, $urandom, 1'b0, 1'b1);
      repeat (12) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

      $display("[TB] full FIFO with simultaneous push and pop");
      fires = 0;
      t0    = -1;
      for (int n = 0; n < 30 && fires < FIFO_DEPTH; n++) begin
         applyStimulus(1'b1, $urandom, 1'b0, 1'b1);
         if (lastFire) begin
            if (fires == 0) t0 = cyc;
            fires++;
         end
      end
      checkOutput("credit_accepts", 32'(fires), 32'(FIFO_DEPTH));
      if (t0 >= 0) begin
         while (cyc + 1 < t0 + CORE_LATENCY + FIFO_DEPTH - 1) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
         applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
      end
      repeat (12) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

      $display("[TB] reset with work in flight and in the FIFO");
      repeat (5) applyStimulus(1'b1, $urandom, 1'b0, 1'b1);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      repeat (10) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
      applyStimulus(1'b1, 32'hCAFE_0000, 1'b1, 1'b1);
      repeat (8) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

      $display("[TB] random traffic");
      for (int n = 0; n < 400; n++) begin
         applyStimulus(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) != 0),
                       ($urandom_range(0, 99) != 0));
      end
      repeat (20) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
      @(negedge clk);
      checkOutput("drained", 32'(expQ.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
